// File: rtl/design_select_sequencer.sv
// design_select_sequencer: synchronizes and debounces a design selection, then sequences chip selects and resets
module design_select_sequencer #(
  parameter int NUM_DESIGNS   = 12,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int RESET_CYCLES  = 8,
  parameter int DRAIN_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             design_select_in,
  output logic [NUM_DESIGNS-1:0] designs_ncs,
  output logic [NUM_DESIGNS-1:0] designs_n_rst,
  output logic [3:0]             active_select,
  output logic                   gpio_en,
  output logic                   busy
);
  localparam int MAX_AB = STABLE_CYCLES > RESET_CYCLES ? STABLE_CYCLES : RESET_CYCLES;
  localparam int MAX_C  = MAX_AB > DRAIN_CYCLES ? MAX_AB : DRAIN_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam logic [4:0] MAX_SEL = 5'(NUM_DESIGNS);
  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [3:0]             sync_q [SYNC_STAGES];
  logic [3:0]             sel_sync, cand, sel_stable;
  logic [CW-1:0]          cnt, cycle_cnt;
  logic [1:0]             state;
  logic                   stable_valid;
  logic [NUM_DESIGNS-1:0] sel_onehot;

  assign sel_sync     = sync_q[SYNC_STAGES-1];
  assign stable_valid = sel_stable != 4'd0 && {1'b0, sel_stable} <= MAX_SEL;

  // Metastability chain on the raw pad selection
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    else begin
      sync_q[0] <= design_select_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end

  // Accept a selection only after it has held steady; counter saturates rather than wrapping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cand       <= '0;
      cnt        <= '0;
      sel_stable <= '0;
    end else if (sel_sync != cand) begin
      cand <= sel_sync;
      cnt  <= '0;
    end else if (cnt == CW'(STABLE_CYCLES - 1)) sel_stable <= cand;
    else cnt <= cnt + 1'b1;

  // Switch sequencing: drain everything, hold the new design in reset, then let it run
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= S_OFF;
      active_select <= '0;
      cycle_cnt     <= '0;
    end else case (state)
      S_OFF:
        if (stable_valid) begin
          state         <= S_RESET;
          active_select <= sel_stable;
          cycle_cnt     <= '0;
        end
      S_RESET:
        if (sel_stable != active_select) begin
          state     <= S_DRAIN;
          cycle_cnt <= '0;
        end else if (cycle_cnt == CW'(RESET_CYCLES - 1)) state <= S_RUN;
        else cycle_cnt <= cycle_cnt + 1'b1;
      S_RUN:
        if (sel_stable != active_select) begin
          state     <= S_DRAIN;
          cycle_cnt <= '0;
        end
      default:
        if (cycle_cnt == CW'(DRAIN_CYCLES - 1)) begin
          state         <= stable_valid ? S_RESET : S_OFF;
          active_select <= stable_valid ? sel_stable : 4'd0;
          cycle_cnt     <= '0;
        end else cycle_cnt <= cycle_cnt + 1'b1;
    endcase

  // One-hot decode of the owning design
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_DESIGNS; i++) sel_onehot[i] = active_select == 4'(i + 1);
  end

  assign designs_ncs   = (state == S_RESET || state == S_RUN) ? ~sel_onehot : '1;
  assign designs_n_rst = state == S_RUN ? sel_onehot : '0;
  assign gpio_en       = state == S_RUN;
  assign busy          = state == S_RESET || state == S_DRAIN;
endmodule
